// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.
// Defining IDEX_PERF_CNT_EN adds saturating stall/flush event counters (perf_stall_cnt, perf_flush_cnt).
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RA_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [1:0]        id_RegDst,
    input  logic [1:0]        id_ALUSrcA,
    input  logic [1:0]        id_ALUSrcB,
    input  logic [1:0]        id_MemtoReg,
    input  logic [1:0]        id_Jump,
    input  logic [4:0]        id_ALUOp,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_RegWrite,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_rs_addr,
    output logic [4:0]        ex_rt_addr,
    output logic [4:0]        ex_wr_addr,
    output logic [1:0]        ex_RegDst,
    output logic [1:0]        ex_ALUSrcA,
    output logic [1:0]        ex_ALUSrcB,
    output logic [1:0]        ex_MemtoReg,
    output logic [1:0]        ex_Jump,
    output logic [4:0]        ex_ALUOp,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_RegWrite
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    typedef struct packed {
        logic signed [DATA_W-1:0] pc;
        logic signed [DATA_W-1:0] rs_data;
        logic signed [DATA_W-1:0] rt_data;
        logic signed [DATA_W-1:0] imm;
        logic [4:0]               shamt;
        logic [4:0]               rs_addr;
        logic [4:0]               rt_addr;
        logic [4:0]               wr_addr;
        logic [1:0]               regdst;
        logic [1:0]               alusrca;
        logic [1:0]               alusrcb;
        logic [1:0]               memtoreg;
        logic [1:0]               jump;
        logic [4:0]               aluop;
        logic                     memread;
        logic                     memwrite;
        logic                     regwrite;
    } idex_t;

    function automatic logic [4:0] dest_sel(input logic [1:0] regdst,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        case (regdst)
            2'b00:   dest_sel = rt;
            2'b01:   dest_sel = rd;
            2'b10:   dest_sel = 5'(RA_REG);
            default: dest_sel = 5'd0;
        endcase
    endfunction

    idex_t      cap_p0;
    idex_t      stage_p1;
    logic       vld_p1;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_is_j;
    logic       stall;
    logic       unused_funct;

    assign id_rs        = id_instr[25:21];
    assign id_rt        = id_instr[20:16];
    assign id_is_j      = (id_instr[31:26] == 6'b000010) || (id_instr[31:26] == 6'b000011);
    assign unused_funct = ^id_instr[5:0];

    // Load in EX whose destination is read by ID; j/jal carry no rt operand.
    assign stall = vld_p1 & stage_p1.memread & (stage_p1.wr_addr != 5'd0) & id_valid & ~ex_flush &
                   ((stage_p1.wr_addr == id_rs) | ((stage_p1.wr_addr == id_rt) & ~id_is_j));

    // ---- p0: capture word built from the ID slot ----
    always_comb begin
        cap_p0          = '0;
        cap_p0.pc       = $signed(id_pc);
        cap_p0.rs_data  = $signed(id_rs_data);
        cap_p0.rt_data  = $signed(id_rt_data);
        cap_p0.imm      = $signed(id_imm_ext);
        cap_p0.shamt    = id_instr[10:6];
        cap_p0.rs_addr  = id_rs;
        cap_p0.rt_addr  = id_rt;
        cap_p0.wr_addr  = dest_sel(id_RegDst, id_rt, id_instr[15:11]);
        cap_p0.regdst   = id_RegDst;
        cap_p0.alusrca  = id_ALUSrcA;
        cap_p0.alusrcb  = id_ALUSrcB;
        cap_p0.memtoreg = id_MemtoReg;
        cap_p0.jump     = id_valid ? id_Jump : 2'b00;
        cap_p0.aluop    = id_ALUOp;
        cap_p0.memread  = id_valid & id_MemRead;
        cap_p0.memwrite = id_valid & id_MemWrite;
        cap_p0.regwrite = id_valid & id_RegWrite;
    end

    // ---- p1: EX slot register; flush and stall both load an all-zero bubble ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            stage_p1 <= '0;
        end else if (!hold) begin
            if (ex_flush || stall) begin
                vld_p1   <= 1'b0;
                stage_p1 <= '0;
            end else begin
                vld_p1   <= id_valid;
                stage_p1 <= cap_p0;
            end
        end
    end

    assign stall_out   = stall;
    assign ex_valid    = vld_p1;
    assign ex_pc       = stage_p1.pc;
    assign ex_rs_data  = stage_p1.rs_data;
    assign ex_rt_data  = stage_p1.rt_data;
    assign ex_imm      = stage_p1.imm;
    assign ex_shamt    = stage_p1.shamt;
    assign ex_rs_addr  = stage_p1.rs_addr;
    assign ex_rt_addr  = stage_p1.rt_addr;
    assign ex_wr_addr  = stage_p1.wr_addr;
    assign ex_RegDst   = stage_p1.regdst;
    assign ex_ALUSrcA  = stage_p1.alusrca;
    assign ex_ALUSrcB  = stage_p1.alusrcb;
    assign ex_MemtoReg = stage_p1.memtoreg;
    assign ex_Jump     = stage_p1.jump;
    assign ex_ALUOp    = stage_p1.aluop;
    assign ex_MemRead  = stage_p1.memread;
    assign ex_MemWrite = stage_p1.memwrite;
    assign ex_RegWrite = stage_p1.regwrite;

`ifdef IDEX_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_p1;
    logic [15:0] flush_cnt_p1;

    // ---- p1: event counters, frozen with the pipeline ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_p1 <= 16'd0;
            flush_cnt_p1 <= 16'd0;
        end else if (!hold) begin
            if (stall)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            if (ex_flush)
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end
    end

    assign perf_stall_cnt = stall_cnt_p1;
    assign perf_flush_cnt = flush_cnt_p1;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard/flush/hold cases plus
// randomized traffic compared against a behavioural model of the EX slot.
module tb_id_ex_stage_reg;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [DATA_W-1:0] id_pc, id_rs_data, id_rt_data, id_imm_ext;
    logic [1:0]        id_RegDst, id_ALUSrcA, id_ALUSrcB, id_MemtoReg, id_Jump;
    logic [4:0]        id_ALUOp;
    logic              id_MemRead, id_MemWrite, id_RegWrite, ex_flush, hold;
    logic              stall_out, ex_valid;
    logic [DATA_W-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]        ex_shamt, ex_rs_addr, ex_rt_addr, ex_wr_addr;
    logic [1:0]        ex_RegDst, ex_ALUSrcA, ex_ALUSrcB, ex_MemtoReg, ex_Jump;
    logic [4:0]        ex_ALUOp;
    logic              ex_MemRead, ex_MemWrite, ex_RegWrite;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0]       perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(DATA_W), .RA_REG(31)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_RegDst(id_RegDst), .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB),
        .id_MemtoReg(id_MemtoReg), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite),
        .ex_flush(ex_flush), .hold(hold), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_shamt(ex_shamt), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_wr_addr(ex_wr_addr), .ex_RegDst(ex_RegDst), .ex_ALUSrcA(ex_ALUSrcA),
        .ex_ALUSrcB(ex_ALUSrcB), .ex_MemtoReg(ex_MemtoReg), .ex_Jump(ex_Jump),
        .ex_ALUOp(ex_ALUOp), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite)
`ifdef IDEX_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of the EX slot; ctl = {RegDst,ALUSrcA,ALUSrcB,MemtoReg,Jump,ALUOp,MemRead,MemWrite,RegWrite}
    bit          m_v;
    logic [31:0] m_pc, m_rs, m_rt, m_imm;
    logic [4:0]  m_sh, m_rsa, m_rta, m_wr;
    logic [17:0] m_ctl;
    int          m_scnt, m_fcnt;

    task automatic ref_clear();
        m_v = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_imm = 0;
        m_sh = 0; m_rsa = 0; m_rta = 0; m_wr = 0; m_ctl = 0;
    endtask

    function automatic bit ref_stall();
        logic [4:0] rs = id_instr[25:21];
        logic [4:0] rt = id_instr[20:16];
        bit jtype = (id_instr[31:26] == 6'd2) || (id_instr[31:26] == 6'd3);
        bit load_in_ex = m_v && m_ctl[2];
        return load_in_ex && (m_wr != 0) && id_valid && !ex_flush &&
               ((m_wr == rs) || ((m_wr == rt) && !jtype));
    endfunction

    task automatic ref_edge(input bit st);
        if (hold) return;
        if (ex_flush && m_fcnt < 65535) m_fcnt++;
        if (st && m_scnt < 65535) m_scnt++;
        if (ex_flush || st) begin
            ref_clear();
            return;
        end
        m_v = id_valid; m_pc = id_pc; m_rs = id_rs_data; m_rt = id_rt_data; m_imm = id_imm_ext;
        m_sh = id_instr[10:6]; m_rsa = id_instr[25:21]; m_rta = id_instr[20:16];
        case (id_RegDst)
            2'd0: m_wr = id_instr[20:16];
            2'd1: m_wr = id_instr[15:11];
            2'd2: m_wr = 5'd31;
            default: m_wr = 5'd0;
        endcase
        m_ctl = {id_RegDst, id_ALUSrcA, id_ALUSrcB, id_MemtoReg, id_valid ? id_Jump : 2'b00,
                 id_ALUOp, id_valid & id_MemRead, id_valid & id_MemWrite, id_valid & id_RegWrite};
    endtask

    task automatic check_regs();
        chk("ex_valid", 32'(ex_valid), 32'(m_v));
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_rs_data", ex_rs_data, m_rs);
        chk("ex_rt_data", ex_rt_data, m_rt);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_fields", 32'({ex_shamt, ex_rs_addr, ex_rt_addr}), 32'({m_sh, m_rsa, m_rta}));
        chk("ex_wr_addr", 32'(ex_wr_addr), 32'(m_wr));
        chk("ex_ctl", 32'({ex_RegDst, ex_ALUSrcA, ex_ALUSrcB, ex_MemtoReg, ex_Jump, ex_ALUOp,
                           ex_MemRead, ex_MemWrite, ex_RegWrite}), 32'(m_ctl));
`ifdef IDEX_PERF_CNT_EN
        chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'(m_scnt));
        chk("perf_flush_cnt", 32'(perf_flush_cnt), 32'(m_fcnt));
`endif
    endtask

    // Called at posedge+1; checks the hazard output, clocks one edge, checks the registers.
    task automatic step();
        bit st;
        @(negedge clk);
        st = ref_stall();
        chk("stall_out", 32'(stall_out), 32'(st));
        @(posedge clk);
        ref_edge(st);
        #1;
        check_regs();
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [1:0] regdst,
                          input logic memread, input logic regwrite);
        id_valid    = 1'b1; ex_flush = 1'b0; hold = 1'b0;
        id_instr    = {op, rs, rt, rd, 5'($urandom), 6'($urandom)};
        id_pc       = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
        id_RegDst   = regdst; id_ALUSrcA = 2'b00; id_ALUSrcB = memread ? 2'b01 : 2'b00;
        id_MemtoReg = memread ? 2'b01 : 2'b00;
        id_Jump     = (op == 6'd2 || op == 6'd3) ? 2'b01 : 2'b00;
        id_ALUOp    = 5'($urandom); id_MemRead = memread; id_MemWrite = 1'b0; id_RegWrite = regwrite;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(2))
            0: return 5'd0;
            1: return 5'd3;
            default: return 5'd8;
        endcase
    endfunction

    // rs of jump-type ops is kept away from any reachable load destination
    task automatic rand_id();
        logic [5:0] op;
        case ($urandom_range(3))
            0: op = 6'h23;
            1: op = 6'h00;
            2: op = 6'h02;
            default: op = 6'h03;
        endcase
        id_instr = $urandom;
        id_instr[31:26] = op;
        id_instr[25:21] = (op == 6'h02 || op == 6'h03) ? 5'd20 : pick_reg();
        id_instr[20:16] = pick_reg();
        id_instr[15:11] = pick_reg();
        id_valid   = ($urandom_range(7) != 0);
        id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
        id_RegDst  = 2'($urandom); id_ALUSrcA = 2'($urandom); id_ALUSrcB = 2'($urandom);
        id_MemtoReg = 2'($urandom); id_Jump = 2'($urandom); id_ALUOp = 5'($urandom);
        id_MemRead = ($urandom_range(2) == 0); id_MemWrite = 1'($urandom); id_RegWrite = 1'($urandom);
        ex_flush   = ($urandom_range(7) == 0);
        hold       = ($urandom_range(7) == 0);
    endtask

    initial begin
        rst = 1'b1;
        set_id(6'h00, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        id_valid = 1'b0;
        ref_clear(); m_scnt = 0; m_fcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("rst_stall", 32'(stall_out), 32'd0);
        rst = 1'b0;

        // destination resolution
        set_id(6'h00, 5'd4, 5'd6, 5'd5, 2'b01, 1'b0, 1'b1); step();
        chk("dst_rd", 32'(ex_wr_addr), 32'd5);
        chk("dst_rs_data", ex_rs_data, id_rs_data);
        set_id(6'h03, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b1); step();
        chk("dst_ra", 32'(ex_wr_addr), 32'd31);
        set_id(6'h23, 5'd2, 5'd9, 5'd7, 2'b00, 1'b1, 1'b1); step();
        chk("dst_rt", 32'(ex_wr_addr), 32'd9);
        set_id(6'h00, 5'd2, 5'd9, 5'd7, 2'b11, 1'b0, 1'b1); step();
        chk("dst_11", 32'(ex_wr_addr), 32'd0);

        // load-use: lw $8 then addu $3,$8,$2
        set_id(6'h23, 5'd1, 5'd8, 5'd0, 2'b00, 1'b1, 1'b1); step();
        set_id(6'h00, 5'd8, 5'd2, 5'd3, 2'b01, 1'b0, 1'b1);
        #1 chk("lu_stall", 32'(stall_out), 32'd1);
        step();
        chk("lu_bubble_rw", 32'(ex_RegWrite), 32'd0);
        chk("lu_bubble_v", 32'(ex_valid), 32'd0);
        #1 chk("lu_once", 32'(stall_out), 32'd0);
        step();
        chk("lu_rs_addr", 32'(ex_rs_addr), 32'd8);
        chk("lu_wr", 32'(ex_wr_addr), 32'd3);

        // load into $0 never stalls
        set_id(6'h23, 5'd1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1); step();
        set_id(6'h00, 5'd0, 5'd0, 5'd3, 2'b01, 1'b0, 1'b1);
        #1 chk("zero_nostall", 32'(stall_out), 32'd0);
        step();

        // jump with rt field aliasing the load destination
        set_id(6'h23, 5'd1, 5'd8, 5'd0, 2'b00, 1'b1, 1'b1); step();
        set_id(6'h02, 5'd0, 5'd8, 5'd0, 2'b00, 1'b0, 1'b0);
        #1 chk("j_nostall", 32'(stall_out), 32'd0);
        step();
        chk("j_captured", 32'(ex_valid), 32'd1);

        // flush beats stall
        set_id(6'h23, 5'd1, 5'd8, 5'd0, 2'b00, 1'b1, 1'b1); step();
        set_id(6'h00, 5'd8, 5'd2, 5'd3, 2'b01, 1'b0, 1'b1);
        ex_flush = 1'b1;
        #1 chk("fl_nostall", 32'(stall_out), 32'd0);
        step();
        chk("fl_bubble", 32'(ex_valid), 32'd0);
        ex_flush = 1'b0;

        // hold during a stall
        set_id(6'h23, 5'd1, 5'd8, 5'd0, 2'b00, 1'b1, 1'b1); step();
        set_id(6'h00, 5'd8, 5'd2, 5'd3, 2'b01, 1'b0, 1'b1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_stall", 32'(stall_out), 32'd1);
            chk("hold_memread", 32'(ex_MemRead), 32'd1);
        end
        hold = 1'b0;
        step();
        chk("hold_rel_bubble", 32'(ex_valid), 32'd0);
        chk("hold_rel_rw", 32'(ex_RegWrite), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rand_id();
            step();
        end

        // async reset mid-cycle with a valid load in EX
        set_id(6'h23, 5'd1, 5'd8, 5'd0, 2'b00, 1'b1, 1'b1); step();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        set_id(6'h00, 5'd8, 5'd2, 5'd3, 2'b01, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        ref_clear(); m_scnt = 0; m_fcnt = 0;
        check_regs();
        chk("rst_async_stall", 32'(stall_out), 32'd0);
        rst = 1'b0;
        #1 chk("rst_no_spurious", 32'(stall_out), 32'd0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
